seven_segment_scanner: RTL and testbench
========================================

// Module: seven_segment_scanner
// PURPOSE
//  Time-multiplexes one shared 7-segment decoder across NUM_DIGITS common-anode digits.
//  Holds a frame of BCD digits, loaded through a valid/ready port. Steps one digit per slot and
//  drives the decoder inputs (digit_data, digit_good) plus active-low anode selects.
//  A blanking dead-time at the start of each slot prevents ghosting. Sits between the
//  datapath producing the values and the board-level decoder/anode pins.
// PARAMETERS
//  NUM_DIGITS    4     digits scanned, >=2
//  PRESCALE      1000  clk cycles per digit slot, >=2
//  BLANK_CYCLES  8     cycles at slot start with all anodes off, 1..PRESCALE-1
// PORTS
//  clk          in   1             system clock, rising edge
//  reset        in   1             synchronous, active-high
//  enable       in   1             1 = scan, 0 = display dark
//  load_valid   in   1             frame offered
//  load_ready   out  1             staging register free
//  load_digits  in   4*NUM_DIGITS  BCD, digit i at [4i+3:4i]
//  load_good    in   NUM_DIGITS    per-digit good flag, passed to decoder
//  digit_data   out  4             to decoder datain
//  digit_good   out  1             to decoder good
//  anode_n      out  NUM_DIGITS    active-low digit enables
//  frame_tick   out  1             1-cycle pulse at start of digit 0 slot
// BEHAVIOUR
//  Reset: anode_n all-1, digit_data=0, digit_good=0, load_ready=1, frame_tick=0.
//   Display and staging regs cleared, pending=0, idx=0, cnt=0, state IDLE. Reset wins over all.
//  FSM IDLE/BLANK/SHOW, registered outputs, state change visible the cycle after the cause:
//   IDLE : anode_n all-1, cnt=idx=0; enable=1 -> BLANK (idx 0, frame_tick=1 that cycle).
//   BLANK: anode_n all-1; cnt==BLANK_CYCLES-1 -> SHOW.
//   SHOW : anode_n = ~(1<<idx); cnt==PRESCALE-1 -> BLANK, idx+1; idx wraps NUM_DIGITS-1 -> 0.
//     frame_tick=1 on the BLANK entry where idx becomes 0.
//   Any state: enable=0 -> IDLE next cycle, anodes off immediately (no slot completion).
//  cnt counts 0..PRESCALE-1 over the whole slot, BLANK then SHOW; width $clog2(PRESCALE).
//  digit_data/digit_good update on BLANK entry from display[idx], stable through SHOW.
//  Load handshake: transfer when load_valid && load_ready; captures into staging, pending=1,
//   load_ready=0 next cycle.
//   Commit staging->display on frame boundary (entry to BLANK with idx 0) or any cycle in IDLE.
//     Then pending=0, load_ready=1 next cycle. Never tears a frame.
//   Transfer and commit in the same cycle: commit uses old staging; new data stays pending.
//   (Only possible in IDLE edge case; load_ready=0 while pending, so just ordering.)
//  enable toggling mid-slot: IDLE restarts at digit 0; pending frame commits in IDLE.
// STRUCTURE
//  seven_seg_defs.vh: state encodings (IDLE=0,BLANK=1,SHOW=2), BCD_W=4, ANODES_OFF.
//  Sub-module scan_slot_timer: cnt/idx counters with wrap and blank/show decode.
//  FSM, staging and handshake stay in the top. Decoder is instantiated by the parent, not here.
// TESTING
//  Reset with enable=1 -> anode_n=4'b1111, load_ready=1, digit_good=0; IDLE until reset low.
//  PRESCALE=10, BLANK=2, load 0x9876 good=4'b1111, enable -> per slot: 2 cycles 1111 then 8 cycles.
//    Sequence 1110/data 6, 1101/7, 1011/8, 0111/9. frame_tick every 40 cycles.
//  Load 0x1234 mid-slot of digit 2 -> load_ready low; old digits to end of frame.
//    New data from next digit-0 slot; load_ready high one cycle after commit.
//  Second load_valid while pending -> held off (ready=0); accepted after commit, no loss/duplication.
//  enable drop during SHOW of digit 3 -> next cycle anode_n=1111.
//    Re-enable -> BLANK at digit 0 with frame_tick=1.
//  Reset asserted mid-SHOW with a pending frame -> all outputs to reset values; pending frame discarded.

Source files
------------

// File: rtl/seven_segment_scanner_pkg.sv
// Shared encodings for the seven-segment scanner: FSM states and BCD digit width.
package seven_segment_scanner_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  localparam int BCD_W = 4;

endpackage

// File: rtl/seven_segment_scanner_slot_timer.sv
// Slot counter (blank then show phases) and digit index with wrap, for the scanner FSM.
module seven_segment_scanner_slot_timer #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 8,
  localparam int CNT_W = $clog2(PRESCALE),
  localparam int IDX_W = $clog2(NUM_DIGITS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             run,
  output logic [IDX_W-1:0] idx,
  output logic [IDX_W-1:0] idx_next,
  output logic             blank_done,
  output logic             slot_end,
  output logic             frame_wrap
);

  logic [CNT_W-1:0] cnt;

  assign blank_done = (cnt == CNT_W'(BLANK_CYCLES - 1));
  assign slot_end   = (cnt == CNT_W'(PRESCALE - 1));
  assign frame_wrap = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));
  assign idx_next   = frame_wrap ? '0 : idx + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
      idx <= '0;
    end else if (run) begin
      if (slot_end) begin
        cnt <= '0;
        idx <= idx_next;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexes one 7-segment decoder across NUM_DIGITS common-anode digits with
// per-slot blanking and a tear-free double-buffered frame load port.
module seven_segment_scanner
  import seven_segment_scanner_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [BCD_W*NUM_DIGITS-1:0]   load_digits,
  input  logic [NUM_DIGITS-1:0]         load_good,
  output logic [BCD_W-1:0]              digit_data,
  output logic                          digit_good,
  output logic [NUM_DIGITS-1:0]         anode_n,
  output logic                          frame_tick
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] ANODES_OFF = '1;

  scan_state_t state;

  logic [BCD_W*NUM_DIGITS-1:0] display_digits, staging_digits, src_digits;
  logic [NUM_DIGITS-1:0]       display_good, staging_good, src_good;
  logic                        pending, transfer, commit, frame_start;
  logic [IDX_W-1:0]            idx, idx_next, sel_idx;
  logic                        blank_done, slot_end, frame_wrap;
  logic                        timer_clear, timer_run;
  int                          sel_base;

  assign timer_clear = !enable || (state == IDLE);
  assign timer_run   = enable && (state != IDLE);

  seven_segment_scanner_slot_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .PRESCALE    (PRESCALE),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (timer_clear),
    .run       (timer_run),
    .idx       (idx),
    .idx_next  (idx_next),
    .blank_done(blank_done),
    .slot_end  (slot_end),
    .frame_wrap(frame_wrap)
  );

  // A frame starts on BLANK entry at digit 0; only there (or while idle) may display change.
  assign frame_start = enable && ((state == IDLE) || ((state == SHOW) && frame_wrap));
  assign commit      = pending && ((state == IDLE) || frame_start);
  assign load_ready  = !pending;
  assign transfer    = load_valid && load_ready;

  assign src_digits = commit ? staging_digits : display_digits;
  assign src_good   = commit ? staging_good : display_good;
  assign sel_idx    = (state == IDLE) ? '0 : idx_next;
  assign sel_base   = BCD_W * int'(sel_idx);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      anode_n        <= ANODES_OFF;
      digit_data     <= '0;
      digit_good     <= 1'b0;
      frame_tick     <= 1'b0;
      pending        <= 1'b0;
      display_digits <= '0;
      display_good   <= '0;
      staging_digits <= '0;
      staging_good   <= '0;
    end else begin
      frame_tick <= 1'b0;
      if (!enable) begin
        state   <= IDLE;
        anode_n <= ANODES_OFF;
      end else begin
        unique case (state)
          IDLE: begin
            state   <= BLANK;
            anode_n <= ANODES_OFF;
          end
          BLANK: if (blank_done) begin
            state   <= SHOW;
            anode_n <= ~(NUM_DIGITS'(1) << idx);
          end
          SHOW: if (slot_end) begin
            state   <= BLANK;
            anode_n <= ANODES_OFF;
          end
          default: begin
            state   <= IDLE;
            anode_n <= ANODES_OFF;
          end
        endcase
        if (frame_start || ((state == SHOW) && slot_end)) begin
          frame_tick <= frame_start;
          digit_data <= src_digits[sel_base +: BCD_W];
          digit_good <= src_good[sel_idx];
        end
      end
      // Commit reads the old staging contents even if a transfer lands the same cycle.
      if (commit) begin
        display_digits <= staging_digits;
        display_good   <= staging_good;
      end
      if (transfer) begin
        staging_digits <= load_digits;
        staging_good   <= load_good;
      end
      pending <= transfer ? 1'b1 : (commit ? 1'b0 : pending);
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner with 4 digits, 10-cycle slots, 2 blank cycles.
module tb_seven_segment_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_digits;
  logic [3:0]  load_good;
  logic [3:0]  digit_data;
  logic        digit_good;
  logic [3:0]  anode_n;
  logic        frame_tick;

  int pass_count = 0;
  int total = 0;
  int pos = 0;

  seven_segment_scanner #(
    .NUM_DIGITS  (4),
    .PRESCALE    (10),
    .BLANK_CYCLES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_digits(load_digits),
    .load_good  (load_good),
    .digit_data (digit_data),
    .digit_good (digit_good),
    .anode_n    (anode_n),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
    pos++;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; load_valid = 1'b0; load_digits = '0; load_good = '0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++;
      if (anode_n !== 4'b1111) $display("FAIL reset_anode: got %b want 1111", anode_n);
      else pass_count++;
      total++;
      if (load_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", load_ready);
      else pass_count++;
      total++;
      if (digit_good !== 1'b0 || digit_data !== 4'h0 || frame_tick !== 1'b0)
        $display("FAIL reset_outputs: good=%b data=%h tick=%b want 0 0 0",
                 digit_good, digit_data, frame_tick);
      else pass_count++;
    end
    enable = 1'b0;
    reset = 1'b0;
    cyc();
    total++;
    if (anode_n !== 4'b1111) $display("FAIL idle_anode: got %b want 1111", anode_n);
    else pass_count++;
  endtask

  task automatic test_scan();
    logic [3:0] exp_an;
    int slot, ph;
    load_valid = 1'b1; load_digits = 16'h9876; load_good = 4'b1111;
    cyc();
    total++;
    if (load_ready !== 1'b0) $display("FAIL load_ready_low: got %b want 0", load_ready);
    else pass_count++;
    load_valid = 1'b0;
    cyc();
    total++;
    if (load_ready !== 1'b1) $display("FAIL idle_commit_ready: got %b want 1", load_ready);
    else pass_count++;
    enable = 1'b1;
    cyc();
    pos = 0;
    for (int i = 0; i <= 40; i++) begin
      slot = (i / 10) % 4;
      ph = i % 10;
      exp_an = (ph < 2) ? 4'b1111 : ~(4'b0001 << slot);
      total++;
      if (anode_n !== exp_an) $display("FAIL scan_anode[%0d]: got %b want %b", i, anode_n, exp_an);
      else pass_count++;
      total++;
      if (digit_data !== 4'(6 + slot))
        $display("FAIL scan_data[%0d]: got %h want %h", i, digit_data, 4'(6 + slot));
      else pass_count++;
      total++;
      if (frame_tick !== (ph == 0 && slot == 0))
        $display("FAIL scan_tick[%0d]: got %b want %b", i, frame_tick, (ph == 0 && slot == 0));
      else pass_count++;
      if (i < 40) cyc();
    end
  endtask

  task automatic test_reload_back_to_back();
    while (pos < 62) cyc();
    load_valid = 1'b1; load_digits = 16'h1234; load_good = 4'b1010;
    cyc();
    total++;
    if (load_ready !== 1'b0) $display("FAIL reload_ready_low: got %b want 0", load_ready);
    else pass_count++;
    load_digits = 16'h5555; load_good = 4'b1111;
    while (pos < 75) cyc();
    total++;
    if (digit_data !== 4'h9 || anode_n !== 4'b0111)
      $display("FAIL old_frame_kept: data=%h anode=%b want 9 0111", digit_data, anode_n);
    else pass_count++;
    while (pos < 79) cyc();
    total++;
    if (load_ready !== 1'b0) $display("FAIL held_off: got %b want 0", load_ready);
    else pass_count++;
    cyc();
    total++;
    if (digit_data !== 4'h4 || digit_good !== 1'b0)
      $display("FAIL new_frame_d0: data=%h good=%b want 4 0", digit_data, digit_good);
    else pass_count++;
    total++;
    if (load_ready !== 1'b1 || frame_tick !== 1'b1)
      $display("FAIL commit_ready: ready=%b tick=%b want 1 1", load_ready, frame_tick);
    else pass_count++;
    cyc();
    total++;
    if (load_ready !== 1'b0) $display("FAIL second_accept: got %b want 0", load_ready);
    else pass_count++;
    load_valid = 1'b0;
    while (pos < 92) cyc();
    total++;
    if (digit_data !== 4'h3 || digit_good !== 1'b1 || anode_n !== 4'b1101)
      $display("FAIL new_frame_d1: data=%h good=%b anode=%b want 3 1 1101",
               digit_data, digit_good, anode_n);
    else pass_count++;
    while (pos < 105) cyc();
    total++;
    if (digit_data !== 4'h2 || digit_good !== 1'b0 || anode_n !== 4'b1011)
      $display("FAIL new_frame_d2: data=%h good=%b anode=%b want 2 0 1011",
               digit_data, digit_good, anode_n);
    else pass_count++;
    while (pos < 115) cyc();
    total++;
    if (digit_data !== 4'h1 || digit_good !== 1'b1 || load_ready !== 1'b0)
      $display("FAIL new_frame_d3: data=%h good=%b ready=%b want 1 1 0",
               digit_data, digit_good, load_ready);
    else pass_count++;
    while (pos < 120) cyc();
    total++;
    if (digit_data !== 4'h5 || load_ready !== 1'b1 || frame_tick !== 1'b1)
      $display("FAIL second_frame: data=%h ready=%b tick=%b want 5 1 1",
               digit_data, load_ready, frame_tick);
    else pass_count++;
    cyc();
    total++;
    if (load_ready !== 1'b1) $display("FAIL no_duplicate: got %b want 1", load_ready);
    else pass_count++;
  endtask

  task automatic test_enable_drop();
    while (pos < 155) cyc();
    total++;
    if (anode_n !== 4'b0111 || digit_data !== 4'h5)
      $display("FAIL pre_drop: anode=%b data=%h want 0111 5", anode_n, digit_data);
    else pass_count++;
    enable = 1'b0;
    cyc();
    total++;
    if (anode_n !== 4'b1111) $display("FAIL drop_anode: got %b want 1111", anode_n);
    else pass_count++;
    load_valid = 1'b1; load_digits = 16'h4321; load_good = 4'b1111;
    cyc();
    total++;
    if (load_ready !== 1'b0 || anode_n !== 4'b1111 || frame_tick !== 1'b0)
      $display("FAIL idle_load: ready=%b anode=%b tick=%b want 0 1111 0",
               load_ready, anode_n, frame_tick);
    else pass_count++;
    load_valid = 1'b0;
    cyc();
    total++;
    if (load_ready !== 1'b1) $display("FAIL idle_commit: got %b want 1", load_ready);
    else pass_count++;
    enable = 1'b1;
    cyc();
    pos = 0;
    total++;
    if (frame_tick !== 1'b1 || digit_data !== 4'h1 || anode_n !== 4'b1111)
      $display("FAIL reenable: tick=%b data=%h anode=%b want 1 1 1111",
               frame_tick, digit_data, anode_n);
    else pass_count++;
    cyc();
    cyc();
    total++;
    if (anode_n !== 4'b1110 || frame_tick !== 1'b0)
      $display("FAIL reenable_show: anode=%b tick=%b want 1110 0", anode_n, frame_tick);
    else pass_count++;
  endtask

  task automatic test_reset_mid();
    while (pos < 13) cyc();
    load_valid = 1'b1; load_digits = 16'h7777; load_good = 4'b1111;
    cyc();
    total++;
    if (load_ready !== 1'b0) $display("FAIL mid_pending: got %b want 0", load_ready);
    else pass_count++;
    load_valid = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    total++;
    if (anode_n !== 4'b1111 || digit_data !== 4'h0 || digit_good !== 1'b0 ||
        load_ready !== 1'b1 || frame_tick !== 1'b0)
      $display("FAIL mid_reset: anode=%b data=%h good=%b ready=%b tick=%b want 1111 0 0 1 0",
               anode_n, digit_data, digit_good, load_ready, frame_tick);
    else pass_count++;
    cyc();
    total++;
    if (anode_n !== 4'b1111) $display("FAIL mid_reset_hold: got %b want 1111", anode_n);
    else pass_count++;
    reset = 1'b0;
    cyc();
    pos = 0;
    total++;
    if (frame_tick !== 1'b1 || digit_data !== 4'h0 || digit_good !== 1'b0)
      $display("FAIL post_reset_start: tick=%b data=%h good=%b want 1 0 0",
               frame_tick, digit_data, digit_good);
    else pass_count++;
    while (pos < 5) cyc();
    total++;
    if (anode_n !== 4'b1110 || digit_data !== 4'h0)
      $display("FAIL post_reset_show: anode=%b data=%h want 1110 0", anode_n, digit_data);
    else pass_count++;
    while (pos < 40) cyc();
    total++;
    if (frame_tick !== 1'b1 || digit_data !== 4'h0 || load_ready !== 1'b1)
      $display("FAIL discarded_frame: tick=%b data=%h ready=%b want 1 0 1",
               frame_tick, digit_data, load_ready);
    else pass_count++;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_reload_back_to_back();
    test_enable_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_count, total);
    $finish;
  end

endmodule
